// File: rtl/dm_ctrl.sv
// dm_ctrl: byte/half/word data memory with registered reads, post-reset clear engine and misalign/oob flags.
// Define DM_TRACE_EN to print a trace line for every committed store.
module dm_ctrl #(
  parameter int DEPTH_LOG2 = 11,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        oob
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_next;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] cnt, idx, mem_wa;
  logic acc, mis, oor, st_ok, mem_we;
  logic [3:0] be;
  logic [31:0] old, wrep, merged, sh, ext, mem_wd;
  assign ready = state == IDLE;
  assign acc = ready && req;
  assign idx = addr[DEPTH_LOG2+1:2];
  assign old = mem[idx];
  assign oor = |addr[31:DEPTH_LOG2+2];
  always_comb begin
    mis = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    be = size == 2'b00 ? 4'b0001 << addr[1:0] : size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    merged = old;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : old[8*i +: 8];
    sh = old >> {addr[1:0], 3'b000};
    ext = size == 2'b00 ? {{24{sext & sh[7]}}, sh[7:0]} :
          size == 2'b01 ? {{16{sext & sh[15]}}, sh[15:0]} : old;
    st_ok = acc && we && !mis && !oor;
    mem_we = reset_n && (state == CLEAR || st_ok);
    mem_wa = state == CLEAR ? cnt : idx;
    mem_wd = state == CLEAR ? '0 : merged;
    state_next = (state == CLEAR && cnt == '1) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
      misalign <= 1'b0;
      oob <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= state == CLEAR ? cnt + 1'b1 : cnt;
      rvalid <= acc && !we;
      misalign <= acc && mis;
      oob <= acc && oor;
      if (acc && !we) rdata <= (mis || oor) ? '0 : ext;
    end
  end
`ifdef DM_TRACE_EN
  always_ff @(posedge clk)
    if (reset_n && st_ok) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: table-driven check of dm_ctrl (DEPTH_LOG2=4) plus reset/clear corner sequences.
module tb_dm_ctrl;
  logic clk = 0, reset_n = 0, req = 0, we = 0, sext = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, pc = 0;
  logic ready, rvalid, misalign, oob;
  logic [31:0] rdata;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dm_ctrl #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .rvalid(rvalid),
    .rdata(rdata), .misalign(misalign), .oob(oob)
  );
  typedef struct {
    logic w; logic [1:0] s; logic x; logic [31:0] a, d;
    logic ev, em, eo; logic [31:0] er;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(logic w, logic [1:0] s, logic x, logic [31:0] a, logic [31:0] d,
                              logic ev, logic em, logic eo, logic [31:0] er);
    vec_t v;
    v.w = w; v.s = s; v.x = x; v.a = a; v.d = d; v.ev = ev; v.em = em; v.eo = eo; v.er = er;
    return v;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic op(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a, input logic [31:0] d);
    req = 1; we = w; size = s; sext = x; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 0;
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(n), 64'd16);
  endtask
  initial begin
    logic [31:0] last_rd;
    last_rd = 0;
    vt.push_back(mk(0, 2'd2, 0, 32'h3C, 0,            1, 0, 0, 32'h0));
    vt.push_back(mk(1, 2'd2, 0, 32'h10, 32'h11223344, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd0, 1, 32'h13, 0,            1, 0, 0, 32'h00000011));
    vt.push_back(mk(0, 2'd0, 0, 32'h10, 0,            1, 0, 0, 32'h00000044));
    vt.push_back(mk(0, 2'd1, 1, 32'h12, 0,            1, 0, 0, 32'h00001122));
    vt.push_back(mk(1, 2'd2, 0, 32'h20, 32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk(1, 2'd0, 0, 32'h21, 32'hFF80,     0, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd0, 1, 32'h21, 0,            1, 0, 0, 32'hFFFFFF80));
    vt.push_back(mk(0, 2'd2, 0, 32'h20, 0,            1, 0, 0, 32'h00008000));
    vt.push_back(mk(0, 2'd1, 0, 32'h20, 0,            1, 0, 0, 32'h00008000));
    vt.push_back(mk(0, 2'd1, 1, 32'h20, 0,            1, 0, 0, 32'hFFFF8000));
    vt.push_back(mk(1, 2'd1, 0, 32'h32, 32'hBEEF,     0, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h30, 0,            1, 0, 0, 32'hBEEF0000));
    vt.push_back(mk(1, 2'd1, 0, 32'h31, 32'h1234,     0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h22, 0,            1, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h30, 0,            1, 0, 0, 32'hBEEF0000));
    vt.push_back(mk(0, 2'd3, 0, 32'h30, 0,            1, 1, 0, 32'h0));
    vt.push_back(mk(1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 0, 0, 1, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h00, 0,            1, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h40, 0,            1, 0, 1, 32'h0));
    vt.push_back(mk(1, 2'd1, 0, 32'h41, 32'h1,        0, 1, 1, 32'h0));
    vt.push_back(mk(0, 2'd0, 0, 32'h33, 0,            1, 0, 0, 32'h000000BE));
    vt.push_back(mk(0, 2'd0, 1, 32'h33, 0,            1, 0, 0, 32'hFFFFFFBE));
    vt.push_back(mk(1, 2'd2, 0, 32'h3C, 32'hCAFEF00D, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h3C, 0,            1, 0, 0, 32'hCAFEF00D));
    vt.push_back(mk(0, 2'd1, 1, 32'h3E, 0,            1, 0, 0, 32'hFFFFCAFE));
    vt.push_back(mk(0, 2'd0, 1, 32'h31, 0,            1, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h80000010, 0,      1, 0, 1, 32'h0));
    @(posedge clk); #1;
    check("reset_outputs", 64'({ready, rvalid, misalign, oob, rdata}), 64'h0);
    reset_n = 1;
    wait_ready("clear_length");
    foreach (vt[i]) begin
      op(vt[i].w, vt[i].s, vt[i].x, vt[i].a, vt[i].d);
      check($sformatf("vec%0d", i), 64'({rvalid, misalign, oob, rvalid ? rdata : 32'h0}),
            64'({vt[i].ev, vt[i].em, vt[i].eo, vt[i].ev ? vt[i].er : 32'h0}));
      if (vt[i].ev) last_rd = vt[i].er;
    end
    @(posedge clk); #1;
    check("idle_hold", 64'({rvalid, misalign, oob, rdata}), 64'({3'b000, last_rd}));
    req = 1; we = 0; size = 2'd2; addr = 32'h10; reset_n = 0;
    @(posedge clk); #1;
    check("reset_drops_load", 64'({ready, rvalid, rdata}), 64'h0);
    reset_n = 1; we = 1; addr = 32'h04; wdata = 32'h55;
    repeat (5) @(posedge clk);
    #1;
    check("clear_ignores_req", 64'({ready, rvalid, misalign, oob}), 64'h0);
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1; req = 0;
    wait_ready("clear_restart");
    op(0, 2'd2, 0, 32'h04, 0);
    check("ignored_store", 64'({rvalid, rdata}), 64'({1'b1, 32'h0}));
    op(0, 2'd2, 0, 32'h10, 0);
    check("recleared_10", 64'({rvalid, rdata}), 64'({1'b1, 32'h0}));
    op(0, 2'd2, 0, 32'h3C, 0);
    check("recleared_3c", 64'({rvalid, rdata}), 64'({1'b1, 32'h0}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
